// File: rtl/mode_stopwatch_lap.sv
// mode_stopwatch_lap
//   Stopwatch display mode with start/pause/clear control and a circular lap
//   memory. Time is kept directly as BCD digits MM:SS:CC. The block serves
//   ASCII characters to the shared 2x16 LCD writer through the index/out
//   character-fetch interface.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active low
//   en_100hz   one-cycle 100 Hz tick strobe
//   mode_en    mode selected; when low the buttons are ignored, counting goes on
//   btn_start  start/pause toggle pulse
//   btn_lap    lap capture in RUN, clear in PAUSE
//   btn_view   advance the displayed lap (0 = live time)
//   index      LCD character position, 0-15 line 1, 16-31 line 2
//   out        registered ASCII character for index
//
// state    | meaning
// ---------+------------------------------------------------
// ST_IDLE  | cleared, time held at 00:00:00, shows "RDY"
// ST_RUN   | counting on en_100hz, btn_lap captures laps
// ST_PAUSE | time held, btn_start resumes, btn_lap clears

module mode_stopwatch_lap #(
    parameter int LAP_DEPTH = 4,
    parameter int MIN_MAX   = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_100hz,
    input  logic       mode_en,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       btn_view,
    input  logic [4:0] index,
    output logic [7:0] out
);

    localparam int         PW        = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
    localparam logic [3:0] MM_HI     = 4'(MIN_MAX / 10);
    localparam logic [3:0] MM_LO     = 4'(MIN_MAX % 10);
    localparam logic [3:0] DEPTH_DIG = 4'(LAP_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE
    } state_t;

    state_t        state;
    // tm = {m1, m0, s1, s0, c1, c0}, one BCD digit per nibble
    logic [23:0]   tm;
    logic [23:0]   tm_inc;
    logic [23:0]   lap_mem [LAP_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [3:0]    lap_cnt;
    logic [3:0]    view_sel;

    logic          capture;
    logic          clear;
    logic [PW-1:0] ptr_next;
    int            slot_i;
    logic [23:0]   sel_time;
    logic [7:0]    ch;

    function automatic logic [7:0] dig(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    // BCD ripple increment with wrap at MIN_MAX:59:99
    always_comb begin
        tm_inc = tm;
        if (tm[3:0] != 4'd9) begin
            tm_inc[3:0] = tm[3:0] + 4'd1;
        end else begin
            tm_inc[3:0] = 4'd0;
            if (tm[7:4] != 4'd9) begin
                tm_inc[7:4] = tm[7:4] + 4'd1;
            end else begin
                tm_inc[7:4] = 4'd0;
                if (tm[11:8] != 4'd9) begin
                    tm_inc[11:8] = tm[11:8] + 4'd1;
                end else begin
                    tm_inc[11:8] = 4'd0;
                    if (tm[15:12] != 4'd5) begin
                        tm_inc[15:12] = tm[15:12] + 4'd1;
                    end else begin
                        tm_inc[15:12] = 4'd0;
                        if (tm[23:20] == MM_HI && tm[19:16] == MM_LO) begin
                            tm_inc[23:16] = 8'h00;
                        end else if (tm[19:16] != 4'd9) begin
                            tm_inc[19:16] = tm[19:16] + 4'd1;
                        end else begin
                            tm_inc[19:16] = 4'd0;
                            tm_inc[23:20] = tm[23:20] + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // btn_start has priority over the clear in PAUSE
    assign capture  = mode_en && btn_lap && (state == ST_RUN);
    assign clear    = mode_en && btn_lap && !btn_start && (state == ST_PAUSE);
    assign ptr_next = (wr_ptr == PW'(LAP_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);

    // view_sel=k selects the k-th most recent lap; view_sel <= lap_cnt keeps
    // the sum non-negative
    always_comb begin
        slot_i   = 0;
        sel_time = tm;
        if (view_sel != 4'd0) begin
            slot_i   = (int'(wr_ptr) + LAP_DEPTH - int'(view_sel)) % LAP_DEPTH;
            sel_time = lap_mem[slot_i[PW-1:0]];
        end
    end

    always_comb begin
        ch = 8'h20;
        case (index)
            5'd0:  ch = "S";
            5'd1:  ch = "W";
            5'd3: begin
                case (state)
                    ST_RUN:   ch = "R";
                    ST_PAUSE: ch = "P";
                    default:  ch = "R";
                endcase
            end
            5'd4: begin
                case (state)
                    ST_RUN:   ch = "U";
                    ST_PAUSE: ch = "S";
                    default:  ch = "D";
                endcase
            end
            5'd5: begin
                case (state)
                    ST_RUN:   ch = "N";
                    ST_PAUSE: ch = "E";
                    default:  ch = "Y";
                endcase
            end
            5'd7:  ch = "L";
            5'd8:  ch = dig(lap_cnt);
            5'd9:  ch = "/";
            5'd10: ch = dig(DEPTH_DIG);
            5'd16: ch = (view_sel == 4'd0) ? "T" : "L";
            5'd17: ch = (view_sel == 4'd0) ? "I" : "A";
            5'd18: ch = (view_sel == 4'd0) ? "M" : "P";
            5'd19: ch = (view_sel == 4'd0) ? "E" : dig(view_sel);
            5'd21: ch = dig(sel_time[23:20]);
            5'd22: ch = dig(sel_time[19:16]);
            5'd23: ch = ":";
            5'd24: ch = dig(sel_time[15:12]);
            5'd25: ch = dig(sel_time[11:8]);
            5'd26: ch = ":";
            5'd27: ch = dig(sel_time[7:4]);
            5'd28: ch = dig(sel_time[3:0]);
            default: ch = 8'h20;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            tm       <= '0;
            wr_ptr   <= '0;
            lap_cnt  <= '0;
            view_sel <= '0;
            out      <= 8'h00;
            for (int i = 0; i < LAP_DEPTH; i++) begin
                lap_mem[i] <= '0;
            end
        end else begin
            out <= ch;

            if (state == ST_RUN && en_100hz) begin
                tm <= tm_inc;
            end

            if (mode_en) begin
                case (state)
                    ST_IDLE: begin
                        if (btn_start) state <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (btn_start) state <= ST_PAUSE;
                    end
                    ST_PAUSE: begin
                        if (btn_start)    state <= ST_RUN;
                        else if (btn_lap) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end

            // capture stores the pre-increment time even when a tick coincides
            if (capture) begin
                lap_mem[wr_ptr] <= tm;
                wr_ptr          <= ptr_next;
                if (lap_cnt != DEPTH_DIG) lap_cnt <= lap_cnt + 4'd1;
                view_sel        <= '0;
            end else if (clear) begin
                tm       <= '0;
                wr_ptr   <= '0;
                lap_cnt  <= '0;
                view_sel <= '0;
            end else if (mode_en && btn_view) begin
                view_sel <= (view_sel == lap_cnt) ? 4'd0 : view_sel + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_mode_stopwatch_lap.sv
// Bench for mode_stopwatch_lap: directed scenarios plus a randomized phase,
// every cycle's out compared against a queue-based behavioural model.

module tb_mode_stopwatch_lap;

    localparam int DEPTH  = 4;
    localparam int MM     = 1;
    localparam int PERIOD = (MM + 1) * 6000;

    logic       clk;
    logic       rst;
    logic       en_100hz;
    logic       mode_en;
    logic       btn_start;
    logic       btn_lap;
    logic       btn_view;
    logic [4:0] index;
    logic [7:0] out;

    mode_stopwatch_lap #(.LAP_DEPTH(DEPTH), .MIN_MAX(MM)) dut (
        .clk       (clk),
        .rst       (rst),
        .en_100hz  (en_100hz),
        .mode_en   (mode_en),
        .btn_start (btn_start),
        .btn_lap   (btn_lap),
        .btn_view  (btn_view),
        .index     (index),
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    logic [7:0] last_out;

    // model: state 0=idle 1=run 2=pause, time in centiseconds, laps oldest first
    int m_state;
    int m_time;
    int m_view;
    int laps[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_state = 0;
        m_time  = 0;
        m_view  = 0;
        laps.delete();
    endfunction

    function automatic void model_step(input logic tk, input logic me, input logic s,
                                       input logic l, input logic v);
        int  t_next = m_time;
        int  st     = m_state;
        bit  cap    = 0;
        bit  clr    = 0;
        if (m_state == 1 && tk) t_next = (m_time + 1) % PERIOD;
        if (me) begin
            case (m_state)
                0: if (s) st = 1;
                1: begin
                    if (l) cap = 1;
                    if (s) st = 2;
                end
                default: begin
                    if (s) st = 1;
                    else if (l) clr = 1;
                end
            endcase
        end
        if (cap) begin
            laps.push_back(m_time);
            if (laps.size() > DEPTH) void'(laps.pop_front());
            m_view = 0;
        end else if (clr) begin
            laps.delete();
            t_next = 0;
            m_view = 0;
            st     = 0;
        end else if (me && v) begin
            m_view = (m_view == laps.size()) ? 0 : m_view + 1;
        end
        m_time  = t_next;
        m_state = st;
    endfunction

    function automatic logic [7:0] exp_char(input int idx);
        string st;
        string hdr;
        string full;
        int    t;
        st   = (m_state == 0) ? "RDY" : (m_state == 1) ? "RUN" : "PSE";
        t    = (m_view == 0) ? m_time : laps[laps.size() - m_view];
        hdr  = (m_view == 0) ? "TIME" : $sformatf("LAP%0d", m_view);
        full = {$sformatf("SW %s L%0d/%0d     ", st, laps.size(), DEPTH),
                $sformatf("%s %02d:%02d:%02d   ", hdr, t / 6000, (t / 100) % 60, t % 100)};
        return full[idx];
    endfunction

    task automatic cycle(input logic tk, input logic me, input logic s, input logic l,
                         input logic v, input logic [4:0] idx);
        logic [7:0] exp;
        @(negedge clk);
        en_100hz  = tk;
        mode_en   = me;
        btn_start = s;
        btn_lap   = l;
        btn_view  = v;
        index     = idx;
        exp       = exp_char(int'(idx));
        @(posedge clk);
        #1;
        last_out = out;
        check($sformatf("out[%0d]", idx), {24'h0, out}, {24'h0, exp});
        model_step(tk, me, s, l, v);
    endtask

    task automatic expect_line(input int base, input string s);
        for (int i = 0; i < s.len(); i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'(base + i));
            check($sformatf("line[%0d]", base + i), {24'h0, last_out}, {24'h0, s[i]});
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'($urandom_range(0, 31)));
        end
    endtask

    initial begin
        rst = 1'b0;
        en_100hz = 1'b0; mode_en = 1'b1;
        btn_start = 1'b0; btn_lap = 1'b0; btn_view = 1'b0;
        index = 5'd0;
        model_reset();

        // out held at zero through reset
        for (int i = 0; i < 3; i++) begin
            index = 5'(i * 7);
            @(posedge clk);
            #1;
            check("reset_out", {24'h0, out}, 32'h0);
        end
        @(negedge clk);
        rst = 1'b1;

        expect_line(0, "SW RDY L0/4     ");
        expect_line(16, "TIME 00:00:00   ");

        // count and pause
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd3);
        ticks(6123);
        expect_line(16, "TIME 01:01:23");
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd4);
        expect_line(0, "SW PSE");
        ticks(50);
        expect_line(16, "TIME 01:01:23");

        // resume and wrap at MIN_MAX:59:99
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd5);
        ticks(PERIOD - 1 - 6123);
        expect_line(16, "TIME 01:59:99");
        ticks(1);
        expect_line(16, "TIME 00:00:00");
        expect_line(0, "SW RUN");

        // five laps into four slots, then browse
        for (int k = 0; k < 5; k++) begin
            ticks(100);
            cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd8);
        end
        expect_line(0, "SW RUN L4/4");
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd19);
        expect_line(16, "LAP1 00:05:00");
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd19);
        expect_line(16, "LAP4 00:02:00");
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd19);
        expect_line(16, "TIME 00:05:00");

        // start+lap together in RUN, coinciding with a tick
        ticks(242);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd21);
        expect_line(0, "SW PSE L4/4");
        expect_line(16, "TIME 00:07:43");
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd16);
        expect_line(16, "LAP1 00:07:42");
        // both in PAUSE: resume, no clear
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8);
        expect_line(0, "SW RUN L4/4");
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd8);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8);
        expect_line(0, "SW RDY L0/4");
        expect_line(16, "TIME 00:00:00");

        // mode_en low: buttons ignored, counting continues
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
        ticks(30);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3);
        for (int i = 0; i < 99; i++) begin
            cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
        end
        expect_line(0, "SW RUN L1/4");
        expect_line(16, "TIME 00:01:30");
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd16);
        expect_line(16, "LAP1 00:00:30");

        // reset asserted mid-cycle with a tick and all buttons active
        @(negedge clk);
        en_100hz = 1'b1; mode_en = 1'b1;
        btn_start = 1'b1; btn_lap = 1'b1; btn_view = 1'b1;
        index = 5'd22;
        #2 rst = 1'b0;
        #1 check("rst_async", {24'h0, out}, 32'h0);
        model_reset();
        @(posedge clk);
        #1 check("rst_hold", {24'h0, out}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        en_100hz = 1'b0; btn_start = 1'b0; btn_lap = 1'b0; btn_view = 1'b0;
        expect_line(0, "SW RDY L0/4");
        expect_line(16, "TIME 00:00:00");

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            cycle(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) != 0),
                  1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 14) == 0),
                  1'($urandom_range(0, 5) == 0), 5'($urandom_range(0, 31)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
